// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter
//   Owns the SDRAM command/address bus. Shares it between the write engine and
//   the read engine (one grant at a time) and schedules periodic AUTO REFRESH:
//   when the refresh timer expires, auto_refresh is raised so the granted
//   engine drains. Once nothing is granted, the arbiter itself issues
//   PRECHARGE-ALL, waits T_RP, issues AUTO REFRESH, then waits T_RFC.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   init_done             SDRAM power-up sequence complete
//   wr_req / rd_req       engine has pending work
//   wr_enable / rd_enable grant to the engine
//   wr_idle / rd_idle     engine idle status
//   wr_/rd_command, _address, _bank   engine bus outputs
//   wr_data_mask          write engine DQM
//   auto_refresh          refresh pending (to both engines)
//   sd_command/address/bank/data_mask registered bus (1 cycle latency)
//   refresh_missed        1-cycle pulse: timer expired while still pending
//
// Configuration
//   SDRAM_ARB_RR_EN  defined: ties between wr_req and rd_req go to the engine
//                    not granted last (first tie goes to write).
//                    undefined: write always wins ties.
//
// Command encoding is {RAS_n, CAS_n, WE_n}.

module sdram_cmd_arbiter #(
    parameter int REFRESH_INTERVAL = 1560,
    parameter int T_RP             = 2,
    parameter int T_RFC            = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        wr_req,
    input  logic        rd_req,
    output logic        wr_enable,
    output logic        rd_enable,
    input  logic        wr_idle,
    input  logic        rd_idle,
    input  logic [2:0]  wr_command,
    input  logic [2:0]  rd_command,
    input  logic [11:0] wr_address,
    input  logic [11:0] rd_address,
    input  logic [1:0]  wr_bank,
    input  logic [1:0]  rd_bank,
    input  logic [1:0]  wr_data_mask,
    output logic        auto_refresh,
    output logic [2:0]  sd_command,
    output logic [11:0] sd_address,
    output logic [1:0]  sd_bank,
    output logic [1:0]  sd_data_mask,
    output logic        refresh_missed
);

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;

    localparam int TW   = $clog2(REFRESH_INTERVAL + 1);
    localparam int DMAX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int DW   = $clog2(DMAX + 1);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_INIT_WAIT,
        S_IDLE,
        S_GRANT_WR,
        S_GRANT_RD,
        S_REF_PRE,
        S_REF_CMD
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   delay_reg, delay_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            pending_reg, pending_next;
    logic            missed_reg, missed_next;
    logic            wr_enable_reg, wr_enable_next;
    logic            rd_enable_reg, rd_enable_next;
    logic            grant_long_reg, grant_long_next;  // enable already high >= 1 cycle
    logic [2:0]      cmd_reg, cmd_next;
    logic [11:0]     addr_reg, addr_next;
    logic [1:0]      bank_reg, bank_next;
    logic [1:0]      mask_reg, mask_next;
    logic            issue_ref;
    logic            pick_wr;

`ifdef SDRAM_ARB_RR_EN
    // 1 = write was granted last; resets to read so the first tie goes to write.
    logic last_grant_wr_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_wr_reg <= 1'b0;
        end else if (state_reg == S_IDLE && state_next == S_GRANT_WR) begin
            last_grant_wr_reg <= 1'b1;
        end else if (state_reg == S_IDLE && state_next == S_GRANT_RD) begin
            last_grant_wr_reg <= 1'b0;
        end
    end
    assign pick_wr = wr_req && (!rd_req || !last_grant_wr_reg);
`else
    assign pick_wr = wr_req;
`endif

    // Refresh timer: runs once init_done is high. An expiry while a refresh is
    // still outstanding is reported but not queued.
    always_comb begin
        timer_next   = timer_reg;
        pending_next = pending_reg;
        missed_next  = 1'b0;
        if (issue_ref) begin
            pending_next = 1'b0;
        end
        if (init_done) begin
            if (timer_reg == '0) begin
                timer_next   = TIMER_RELOAD;
                missed_next  = pending_reg && !issue_ref;
                pending_next = 1'b1;
            end else begin
                timer_next = timer_reg - 1'b1;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        delay_next      = delay_reg;
        wr_enable_next  = wr_enable_reg;
        rd_enable_next  = rd_enable_reg;
        grant_long_next = grant_long_reg;
        cmd_next        = CMD_NOP;
        addr_next       = '0;
        bank_next       = '0;
        mask_next       = '0;
        issue_ref       = 1'b0;
        case (state_reg)
            S_INIT_WAIT: begin
                if (init_done) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (pending_reg) begin
                    state_next = S_REF_PRE;
                    cmd_next   = CMD_PRE;
                    addr_next  = 12'h400;
                    delay_next = DW'(T_RP);
                end else if (pick_wr) begin
                    state_next      = S_GRANT_WR;
                    wr_enable_next  = 1'b1;
                    grant_long_next = 1'b0;
                end else if (rd_req) begin
                    state_next      = S_GRANT_RD;
                    rd_enable_next  = 1'b1;
                    grant_long_next = 1'b0;
                end
            end
            S_GRANT_WR: begin
                // Engine outputs pass through for the whole grant, including
                // the drain phase after enable drops (TERM/PRE from the engine).
                cmd_next  = wr_command;
                addr_next = wr_address;
                bank_next = wr_bank;
                mask_next = wr_data_mask;
                if (wr_enable_reg) begin
                    grant_long_next = 1'b1;
                    if (grant_long_reg && (pending_reg || !wr_req)) begin
                        wr_enable_next = 1'b0;
                    end
                end else if (wr_idle) begin
                    if (pending_reg) begin
                        state_next = S_REF_PRE;
                        cmd_next   = CMD_PRE;
                        addr_next  = 12'h400;
                        bank_next  = '0;
                        mask_next  = '0;
                        delay_next = DW'(T_RP);
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_GRANT_RD: begin
                cmd_next  = rd_command;
                addr_next = rd_address;
                bank_next = rd_bank;
                if (rd_enable_reg) begin
                    grant_long_next = 1'b1;
                    if (grant_long_reg && (pending_reg || !rd_req)) begin
                        rd_enable_next = 1'b0;
                    end
                end else if (rd_idle) begin
                    if (pending_reg) begin
                        state_next = S_REF_PRE;
                        cmd_next   = CMD_PRE;
                        addr_next  = 12'h400;
                        bank_next  = '0;
                        delay_next = DW'(T_RP);
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_REF_PRE: begin
                if (delay_reg != '0) begin
                    delay_next = delay_reg - 1'b1;
                end else begin
                    cmd_next   = CMD_REF;
                    issue_ref  = 1'b1;
                    delay_next = DW'(T_RFC);
                    state_next = S_REF_CMD;
                end
            end
            S_REF_CMD: begin
                if (delay_reg != '0) begin
                    delay_next = delay_reg - 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_INIT_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_INIT_WAIT;
            delay_reg      <= '0;
            timer_reg      <= TIMER_RELOAD;
            pending_reg    <= 1'b0;
            missed_reg     <= 1'b0;
            wr_enable_reg  <= 1'b0;
            rd_enable_reg  <= 1'b0;
            grant_long_reg <= 1'b0;
            cmd_reg        <= CMD_NOP;
            addr_reg       <= '0;
            bank_reg       <= '0;
            mask_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            delay_reg      <= delay_next;
            timer_reg      <= timer_next;
            pending_reg    <= pending_next;
            missed_reg     <= missed_next;
            wr_enable_reg  <= wr_enable_next;
            rd_enable_reg  <= rd_enable_next;
            grant_long_reg <= grant_long_next;
            cmd_reg        <= cmd_next;
            addr_reg       <= addr_next;
            bank_reg       <= bank_next;
            mask_reg       <= mask_next;
        end
    end

    assign wr_enable      = wr_enable_reg;
    assign rd_enable      = rd_enable_reg;
    assign auto_refresh   = pending_reg;
    assign refresh_missed = missed_reg;
    assign sd_command     = cmd_reg;
    assign sd_address     = addr_reg;
    assign sd_bank        = bank_reg;
    assign sd_data_mask   = mask_reg;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed testbench for sdram_cmd_arbiter: reset state, refresh sequence,
// write pass-through, tie arbitration, refresh during a write burst,
// missed-refresh reporting and reset during the refresh delay.
// Define SDRAM_ARB_RR_EN for both bench and RTL to exercise round-robin ties.

module tb_sdram_cmd_arbiter;

    localparam logic [2:0] NOP   = 3'b111;
    localparam logic [2:0] ACT   = 3'b011;
    localparam logic [2:0] RD    = 3'b101;
    localparam logic [2:0] WR    = 3'b100;
    localparam logic [2:0] TERM  = 3'b110;
    localparam logic [2:0] PRE   = 3'b010;
    localparam logic [2:0] REF   = 3'b001;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        wr_req, rd_req;
    logic        wr_enable, rd_enable;
    logic        wr_idle, rd_idle;
    logic [2:0]  wr_command, rd_command;
    logic [11:0] wr_address, rd_address;
    logic [1:0]  wr_bank, rd_bank;
    logic [1:0]  wr_data_mask;
    logic        auto_refresh;
    logic [2:0]  sd_command;
    logic [11:0] sd_address;
    logic [1:0]  sd_bank;
    logic [1:0]  sd_data_mask;
    logic        refresh_missed;

    int compared   = 0;
    int mismatched = 0;

    sdram_cmd_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .init_done      (init_done),
        .wr_req         (wr_req),
        .rd_req         (rd_req),
        .wr_enable      (wr_enable),
        .rd_enable      (rd_enable),
        .wr_idle        (wr_idle),
        .rd_idle        (rd_idle),
        .wr_command     (wr_command),
        .rd_command     (rd_command),
        .wr_address     (wr_address),
        .rd_address     (rd_address),
        .wr_bank        (wr_bank),
        .rd_bank        (rd_bank),
        .wr_data_mask   (wr_data_mask),
        .auto_refresh   (auto_refresh),
        .sd_command     (sd_command),
        .sd_address     (sd_address),
        .sd_bank        (sd_bank),
        .sd_data_mask   (sd_data_mask),
        .refresh_missed (refresh_missed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin : stim
        int n;
        int pulses;
        logic rd_seen;
        logic [1:0] who;
        logic [1:0] exp_who;

        rst = 1'b1; init_done = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0; wr_idle = 1'b1; rd_idle = 1'b1;
        wr_command = NOP; rd_command = NOP;
        wr_address = '0; rd_address = '0; wr_bank = '0; rd_bank = '0;
        wr_data_mask = '0;

        // ---- 1: reset state and first refresh ----
        tick(); tick();
        check("rst_cmd", 32'(sd_command), 32'(NOP));
        check("rst_addr", 32'(sd_address), 32'h0);
        check("rst_bank_mask", 32'({sd_bank, sd_data_mask}), 32'h0);
        check("rst_enables", 32'({wr_enable, rd_enable}), 32'h0);
        check("rst_ar_missed", 32'({auto_refresh, refresh_missed}), 32'h0);
        rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!auto_refresh && n < 2000);
        check("ar_rise_cycle", 32'(n), 32'd1560);
        check("ar_rise_bus_nop", 32'(sd_command), 32'(NOP));
        tick();
        check("ref_pre_cmd", 32'(sd_command), 32'(PRE));
        check("ref_pre_a10", 32'(sd_address[10]), 32'h1);
        tick();
        check("trp_nop1", 32'(sd_command), 32'(NOP));
        tick();
        check("trp_nop2", 32'(sd_command), 32'(NOP));
        tick();
        check("ref_cmd", 32'(sd_command), 32'(REF));
        check("ar_fall", 32'(auto_refresh), 32'h0);
        n = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (sd_command === NOP) n++;
        end
        check("trfc_nops", 32'(n), 32'd7);

        // ---- 2: write grant, ACT pass-through ----
        wr_req = 1'b1; wr_idle = 1'b0; wr_command = ACT; wr_bank = 2'd2;
        wr_address = 12'h123; wr_data_mask = 2'b10;
        rd_command = RD; rd_address = 12'hABC; rd_bank = 2'd1;
        n = 0;
        do begin tick(); n++; end while (!wr_enable && n < 20);
        check("wr_grant", 32'({wr_enable, rd_enable}), 32'h2);
        check("grant_edge_nop", 32'(sd_command), 32'(NOP));
        tick();
        check("act_cmd", 32'(sd_command), 32'(ACT));
        check("act_addr", 32'(sd_address), 32'h123);
        check("act_bank", 32'(sd_bank), 32'h2);
        check("act_mask", 32'(sd_data_mask), 32'h2);
        wr_command = NOP;
        tick();
        check("wr_nop_follow", 32'(sd_command), 32'(NOP));
        wr_req = 1'b0; wr_idle = 1'b1;
        n = 0;
        do begin tick(); n++; end while (wr_enable && n < 10);
        check("wr_release", 32'(wr_enable), 32'h0);
        tick(); tick();

        // ---- 3: simultaneous requests ----
        for (int r = 0; r < 4; r++) begin
            wr_req = 1'b1; rd_req = 1'b1;
            n = 0;
            do begin tick(); n++; end while (!wr_enable && !rd_enable && n < 20);
            who = {wr_enable, rd_enable};
`ifdef SDRAM_ARB_RR_EN
            exp_who = (r % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_who = 2'b10;
`endif
            check($sformatf("tie_round%0d", r), 32'(who), 32'(exp_who));
            wr_req = 1'b0; rd_req = 1'b0;
            tick(); tick(); tick(); tick();
        end

        // ---- 4: refresh expiry during a write burst ----
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        wr_req = 1'b1; wr_idle = 1'b0; wr_command = WR; wr_address = 12'h010; wr_bank = 2'd0;
        n = 0;
        do begin tick(); n++; end while (!wr_enable && n < 20);
        rd_req = 1'b1;
        rd_seen = 1'b0;
        n = 0;
        do begin tick(); n++; rd_seen |= rd_enable; end while (!auto_refresh && n < 2000);
        check("burst_ar_seen", 32'(auto_refresh), 32'h1);
        tick();
        check("burst_wr_drop", 32'(wr_enable), 32'h0);
        check("burst_wr_passthru", 32'(sd_command), 32'(WR));
        wr_command = TERM;
        tick();
        check("burst_term", 32'(sd_command), 32'(TERM));
        wr_command = PRE; wr_address = 12'h000; wr_bank = 2'd1;
        tick();
        check("burst_eng_pre", 32'({sd_command, sd_bank, sd_address}), 32'({PRE, 2'd1, 12'h000}));
        wr_command = NOP; wr_idle = 1'b1; wr_req = 1'b0;
        tick();
        rd_seen |= rd_enable;
        check("burst_pre_all", 32'({sd_command, sd_address[10]}), 32'({PRE, 1'b1}));
        n = 0;
        do begin tick(); n++; rd_seen |= rd_enable; end while (sd_command !== REF && n < 10);
        check("burst_ref_delay", 32'(n), 32'd3);
        check("burst_no_rd_grant", 32'(rd_seen), 32'h0);
        n = 0;
        do begin tick(); n++; end while (!rd_enable && n < 15);
        check("post_ref_rd_grant", 32'({wr_enable, rd_enable}), 32'h1);
        rd_req = 1'b0;
        tick(); tick(); tick();

        // ---- 5: engine held busy for > 2 intervals ----
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        wr_req = 1'b1; wr_idle = 1'b0; wr_command = NOP; rd_req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4700; i++) begin
            tick();
            if (refresh_missed === 1'b1) pulses++;
        end
        check("missed_pulses", 32'(pulses), 32'd2);
        check("missed_ar_held", 32'(auto_refresh), 32'h1);
        check("missed_wr_dropped", 32'(wr_enable), 32'h0);

        // ---- 6: reset during the T_RFC delay ----
        wr_idle = 1'b1; wr_req = 1'b0;
        n = 0;
        do begin tick(); n++; end while (sd_command !== REF && n < 10);
        check("rst6_ref_seen", 32'(sd_command), 32'(REF));
        tick(); tick();
        rst = 1'b1; init_done = 1'b0; wr_req = 1'b1; wr_idle = 1'b0; wr_command = ACT;
        tick();
        check("rst6_cmd", 32'(sd_command), 32'(NOP));
        check("rst6_addr", 32'(sd_address), 32'h0);
        check("rst6_enables", 32'({wr_enable, rd_enable}), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("init_wait_no_grant", 32'({wr_enable, sd_command}), 32'({1'b0, NOP}));
        init_done = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!wr_enable && n < 5);
        check("init_done_grant", 32'(wr_enable), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
